// File: rtl/distribution_ram.sv
// Single-port synchronous RAM for LBM distribution vectors: nine signed 32-bit
// lanes per word, write-first, registered read output with asynchronous clear.
module distribution_ram #(
    parameter int DEPTH         = 2304,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 288
) (
    input  logic                            Clk,
    input  logic                            Reset_n,
    input  logic        [ADDRESS_WIDTH-1:0] address,
    input  logic                            WE,
    input  logic signed [DATA_WIDTH-1:0]    data_in,
    output logic signed [DATA_WIDTH-1:0]    data_out
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = ADDRESS_WIDTH'(DEPTH - 1);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];
    logic                         in_range;

    // Addresses past the last word are decoded as holes, never folded back.
    assign in_range = (address <= LAST_ADDRESS);

    // NOTE: the array has no reset so it can map onto block RAM; the
    // contents survive Reset_n and rely on the device's zero power-up state.
    always_ff @(posedge Clk) begin
        if (Reset_n && WE && in_range) begin
            mem[address] <= data_in;
        end
    end

    // Write-first: a write forwards its own data instead of the stale word.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_out <= '0;
        end else if (!in_range) begin
            data_out <= '0;
        end else if (WE) begin
            data_out <= data_in;
        end else begin
            data_out <= mem[address];
        end
    end

endmodule

// File: tb/tb_distribution_ram.sv
// Directed self-checking bench for distribution_ram: reset, readback,
// write-first, address bounds, asynchronous reset and lane signedness.
module tb_distribution_ram;

    localparam int AW = 12;
    localparam int DW = 288;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic        [AW-1:0] address;
    logic                 we;
    logic signed [DW-1:0] data_in;
    logic signed [DW-1:0] data_out;

    int tests  = 0;
    int failed = 0;

    logic [DW-1:0] pat_a;
    logic [DW-1:0] pat_b;
    logic [DW-1:0] ones;
    logic [DW-1:0] held;

    distribution_ram dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .address  (address),
        .WE       (we),
        .data_in  (data_in),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ones = '1;
        for (int k = 0; k < 9; k++) begin
            pat_a[32*k +: 32] = 32'(8 - k) * 32'h1111_1111;
            pat_b[32*k +: 32] = 32'(k) * 32'h1111_1111;
        end

        // Reset holds output at zero and blocks writes.
        rst_n   = 1'b0;
        we      = 1'b1;
        address = '0;
        data_in = ones;
        tick();
        check("reset_edge1", data_out, '0);
        tick();
        check("reset_edge2", data_out, '0);
        rst_n = 1'b1;
        we    = 1'b0;
        tick();
        check("reset_write_blocked", data_out, '0);

        // Write / readback of two patterns.
        we = 1'b1; address = 12'h000; data_in = pat_a;
        tick();
        check("write_a_first", data_out, pat_a);
        address = 12'h012; data_in = pat_b;
        tick();
        check("write_b_first", data_out, pat_b);
        we = 1'b0; address = 12'h000; data_in = ones;
        tick();
        check("read_a", data_out, pat_a);
        address = 12'h012;
        tick();
        check("read_b", data_out, pat_b);

        // Hold: input changes between edges must not move the output.
        address = 12'h000; we = 1'b1;
        #3;
        check("hold_between_edges", data_out, pat_b);
        we = 1'b0;

        // Write-first at a fresh address.
        tick();
        check("read_a_again", data_out, pat_a);
        we = 1'b1; address = 12'h005; data_in = DW'(1);
        tick();
        check("write_first_5", data_out, DW'(1));
        we = 1'b0; data_in = '0;
        tick();
        check("read_5", data_out, DW'(1));

        // Upper bound and out-of-range handling.
        we = 1'b1; address = 12'h8FF; data_in = DW'(16'hDEAD);
        tick();
        check("write_last", data_out, DW'(16'hDEAD));
        we = 1'b0;
        tick();
        check("read_last", data_out, DW'(16'hDEAD));
        we = 1'b1; address = 12'h900; data_in = ones;
        tick();
        check("write_oor_out", data_out, '0);
        we = 1'b0; address = 12'h000;
        tick();
        check("addr0_unchanged", data_out, pat_a);
        address = 12'h100;
        tick();
        check("no_wrap_0x100", data_out, '0);
        address = 12'hFFF;
        tick();
        check("read_oor_top", data_out, '0);

        // Asynchronous reset between edges, memory persists.
        address = 12'h012;
        tick();
        check("pre_reset_read", data_out, pat_b);
        held = data_out;
        #2 rst_n = 1'b0;
        #1;
        check("async_clear", data_out, '0);
        we = 1'b1; data_in = ones;
        tick();
        check("reset_hold_zero", data_out, '0);
        rst_n = 1'b1; we = 1'b0;
        tick();
        check("persist_after_reset", data_out, held);

        // Signedness: every lane of an all-ones word is -1.
        we = 1'b1; address = 12'h007; data_in = ones;
        tick();
        we = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            check($sformatf("lane%0d_minus1", k),
                  DW'($signed(data_out[32*k +: 32]) == -32'sd1), DW'(1));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
